// File: rtl/wb_bus_pkg.sv
// Shared types and default address map for the Wishbone bus decoder.
package wb_bus_pkg;

    typedef enum logic [1:0] {TGT_S0, TGT_S1, TGT_NONE} wb_target_t;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] RAM_MASK    = 32'hF000_0000;
    localparam logic [31:0] PERIPH_BASE = 32'h1000_0000;
    localparam logic [31:0] PERIPH_MASK = 32'hF000_0000;

endpackage

// File: rtl/wb_addr_match.sv
// Masked base-address comparator for one slave region.
module wb_addr_match (
    input  logic [31:0] adr_i,
    input  logic [31:0] base_i,
    input  logic [31:0] mask_i,
    output logic        hit_o
);

    assign hit_o = (adr_i & mask_i) == base_i;

endmodule

// File: rtl/wb_bus_decoder.sv
// Routes one pipelined Wishbone master to RAM / peripheral slaves, answering
// unmapped addresses itself and holding off target switches until drained.
module wb_bus_decoder
    import wb_bus_pkg::*;
#(
    parameter logic [31:0] S0_BASE         = RAM_BASE,
    parameter logic [31:0] S0_MASK         = RAM_MASK,
    parameter logic [31:0] S1_BASE         = PERIPH_BASE,
    parameter logic [31:0] S1_MASK         = PERIPH_MASK,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] s_wb_adr_i,
    input  logic [31:0] s_wb_dat_i,
    output logic [31:0] s_wb_dat_o,
    input  logic [3:0]  s_wb_sel_i,
    input  logic        s_wb_we_i,
    input  logic        s_wb_stb_i,
    input  logic        s_wb_cyc_i,
    output logic        s_wb_ack_o,
    output logic        s_wb_stall_o,
    output logic [31:0] m0_wb_adr_o,
    output logic [31:0] m0_wb_dat_o,
    output logic [3:0]  m0_wb_sel_o,
    output logic        m0_wb_we_o,
    output logic        m0_wb_stb_o,
    output logic        m0_wb_cyc_o,
    input  logic [31:0] m0_wb_dat_i,
    input  logic        m0_wb_ack_i,
    input  logic        m0_wb_stall_i,
    output logic [31:0] m1_wb_adr_o,
    output logic [31:0] m1_wb_dat_o,
    output logic [3:0]  m1_wb_sel_o,
    output logic        m1_wb_we_o,
    output logic        m1_wb_stb_o,
    output logic        m1_wb_cyc_o,
    input  logic [31:0] m1_wb_dat_i,
    input  logic        m1_wb_ack_i,
    input  logic        m1_wb_stall_i
);

    localparam int          CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic          hit0, hit1;
    wb_target_t    dec;
    wb_target_t    target_q, target_d;
    logic [CW-1:0] count_q, count_d;
    logic          ack_pend_q, ack_pend_d;
    logic          busy, own_stall, slv_stall, stall, accept;
    logic          tgt_ack, ack_int;

    wb_addr_match u_match0 (.adr_i(s_wb_adr_i), .base_i(S0_BASE), .mask_i(S0_MASK), .hit_o(hit0));
    wb_addr_match u_match1 (.adr_i(s_wb_adr_i), .base_i(S1_BASE), .mask_i(S1_MASK), .hit_o(hit1));

    always_comb begin
        dec = TGT_NONE;
        if (hit0)      dec = TGT_S0;
        else if (hit1) dec = TGT_S1;
    end

    assign busy      = count_q != '0;
    assign own_stall = (count_q == MAX_CNT) || (busy && dec != target_q);

    always_comb begin
        slv_stall = 1'b0;
        case (dec)
            TGT_S0:  slv_stall = m0_wb_stall_i;
            TGT_S1:  slv_stall = m1_wb_stall_i;
            default: slv_stall = 1'b0;
        endcase
    end

    assign stall  = own_stall | slv_stall;
    assign accept = s_wb_cyc_i & s_wb_stb_i & ~stall;

    // Only the slave that owns the outstanding requests may acknowledge.
    always_comb begin
        tgt_ack    = 1'b0;
        s_wb_dat_o = '0;
        case (target_q)
            TGT_S0: begin
                tgt_ack    = m0_wb_ack_i;
                s_wb_dat_o = m0_wb_dat_i;
            end
            TGT_S1: begin
                tgt_ack    = m1_wb_ack_i;
                s_wb_dat_o = m1_wb_dat_i;
            end
            default: begin
                tgt_ack    = ack_pend_q;
                s_wb_dat_o = '0;
            end
        endcase
    end

    assign ack_int      = s_wb_cyc_i & busy & tgt_ack;
    assign s_wb_ack_o   = ack_int;
    assign s_wb_stall_o = stall & ~rst_i;

    assign m0_wb_adr_o = s_wb_adr_i;
    assign m0_wb_dat_o = s_wb_dat_i;
    assign m0_wb_sel_o = s_wb_sel_i;
    assign m0_wb_we_o  = s_wb_we_i;
    assign m1_wb_adr_o = s_wb_adr_i;
    assign m1_wb_dat_o = s_wb_dat_i;
    assign m1_wb_sel_o = s_wb_sel_i;
    assign m1_wb_we_o  = s_wb_we_i;

    assign m0_wb_stb_o = ~rst_i & s_wb_stb_i & s_wb_cyc_i & (dec == TGT_S0) & ~own_stall;
    assign m1_wb_stb_o = ~rst_i & s_wb_stb_i & s_wb_cyc_i & (dec == TGT_S1) & ~own_stall;
    assign m0_wb_cyc_o = ~rst_i & s_wb_cyc_i & ((busy && target_q == TGT_S0) || dec == TGT_S0);
    assign m1_wb_cyc_o = ~rst_i & s_wb_cyc_i & ((busy && target_q == TGT_S1) || dec == TGT_S1);

    always_comb begin
        count_d    = count_q;
        target_d   = target_q;
        ack_pend_d = 1'b0;
        if (!s_wb_cyc_i) begin
            count_d  = '0;
            target_d = TGT_NONE;
        end else begin
            if (accept) target_d = dec;
            ack_pend_d = accept && dec == TGT_NONE;
            if (accept && !ack_int)      count_d = count_q + 1'b1;
            else if (!accept && ack_int) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q    <= '0;
            target_q   <= TGT_NONE;
            ack_pend_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            target_q   <= target_d;
            ack_pend_q <= ack_pend_d;
        end
    end

endmodule

// File: tb/tb_wb_bus_decoder.sv
// Self-checking bench for wb_bus_decoder: directed table, corner sequences, random vs. model.
module tb_wb_bus_decoder;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, wdat, rdat;
    logic [3:0]  sel;
    logic        we, stb, cyc, ack, stall;
    logic [31:0] m0_adr, m1_adr, m0_wdat, m1_wdat, m0_rdat, m1_rdat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m1_we, m0_stb, m1_stb, m0_cyc, m1_cyc;
    logic        m0_ack, m1_ack, m0_stall, m1_stall;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    wb_bus_decoder #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_wb_adr_i(adr), .s_wb_dat_i(wdat), .s_wb_dat_o(rdat), .s_wb_sel_i(sel),
        .s_wb_we_i(we), .s_wb_stb_i(stb), .s_wb_cyc_i(cyc), .s_wb_ack_o(ack), .s_wb_stall_o(stall),
        .m0_wb_adr_o(m0_adr), .m0_wb_dat_o(m0_wdat), .m0_wb_sel_o(m0_sel), .m0_wb_we_o(m0_we),
        .m0_wb_stb_o(m0_stb), .m0_wb_cyc_o(m0_cyc), .m0_wb_dat_i(m0_rdat), .m0_wb_ack_i(m0_ack),
        .m0_wb_stall_i(m0_stall),
        .m1_wb_adr_o(m1_adr), .m1_wb_dat_o(m1_wdat), .m1_wb_sel_o(m1_sel), .m1_wb_we_o(m1_we),
        .m1_wb_stb_o(m1_stb), .m1_wb_cyc_o(m1_cyc), .m1_wb_dat_i(m1_rdat), .m1_wb_ack_i(m1_ack),
        .m1_wb_stall_i(m1_stall)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        adr = 32'h0; wdat = 32'h0; sel = 4'hF; we = 1'b0; stb = 1'b0; cyc = 1'b1;
        m0_rdat = 32'h0; m1_rdat = 32'h0; m0_ack = 1'b0; m1_ack = 1'b0;
        m0_stall = 1'b0; m1_stall = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [31:0] adr;
        logic        we, stb, a0, a1;
        logic [31:0] d0, d1;
        logic        x_stall, x_ack;
        logic [31:0] x_dat;
        logic        x_s0, x_s1, x_c0, x_c1;
    } vec_t;

    function automatic vec_t mk(logic [31:0] a, logic w, logic s, logic a0, logic a1,
                                logic [31:0] d0, logic [31:0] d1, logic xs, logic xa,
                                logic [31:0] xd, logic s0, logic s1, logic c0, logic c1);
        vec_t v;
        v.adr = a; v.we = w; v.stb = s; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.x_stall = xs; v.x_ack = xa; v.x_dat = xd;
        v.x_s0 = s0; v.x_s1 = s1; v.x_c0 = c0; v.x_c1 = c1;
        return v;
    endfunction

    // Reference model: queue of outstanding request targets (0,1,2=unmapped).
    function automatic int region(logic [31:0] a);
        case (a >> 28)
            32'd0:   return 0;
            32'd1:   return 1;
            default: return 2;
        endcase
    endfunction

    vec_t tbl[11];
    int   oq[$];
    int   last_t, unm_cyc, cno;

    initial begin
        rst = 1'b1;
        idle();
        // Reset state with an aggressive processor and a stalling slave.
        cyc = 1'b1; stb = 1'b1; m0_stall = 1'b1; m0_ack = 1'b1; m0_rdat = 32'h1234_5678;
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_ack", ack, 0);
        chk("rst_dat", rdat, 0);
        chk("rst_m0stb", m0_stb, 0);
        chk("rst_m0cyc", m0_cyc, 0);
        chk("rst_m1cyc", m1_cyc, 0);
        do_reset();

        tbl[0]  = mk(32'h10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        tbl[1]  = mk(32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[2]  = mk(32'h10, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 0, 0, 1, 0);
        tbl[3]  = mk(32'h10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        tbl[4]  = mk(32'h1000_0000, 0, 1, 0, 1, 0, 32'h5555, 1, 0, 0, 0, 0, 1, 1);
        tbl[5]  = mk(32'h1000_0000, 0, 1, 1, 0, 32'h1234, 0, 1, 1, 32'h1234, 0, 0, 1, 1);
        tbl[6]  = mk(32'h1000_0000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        tbl[7]  = mk(32'h1000_0000, 0, 0, 0, 1, 0, 32'hCAFE, 0, 1, 32'hCAFE, 0, 0, 0, 1);
        tbl[8]  = mk(32'h2000_0000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(32'h2000_0000, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[10] = mk(32'h2000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            adr = tbl[i].adr; we = tbl[i].we; stb = tbl[i].stb; cyc = 1'b1;
            m0_ack = tbl[i].a0; m1_ack = tbl[i].a1; m0_rdat = tbl[i].d0; m1_rdat = tbl[i].d1;
            #1;
            chk($sformatf("tbl%0d_stall", i), stall, tbl[i].x_stall);
            chk($sformatf("tbl%0d_ack", i), ack, tbl[i].x_ack);
            chk($sformatf("tbl%0d_dat", i), rdat, tbl[i].x_dat);
            chk($sformatf("tbl%0d_m0stb", i), m0_stb, tbl[i].x_s0);
            chk($sformatf("tbl%0d_m1stb", i), m1_stb, tbl[i].x_s1);
            chk($sformatf("tbl%0d_m0cyc", i), m0_cyc, tbl[i].x_c0);
            chk($sformatf("tbl%0d_m1cyc", i), m1_cyc, tbl[i].x_c1);
            chk($sformatf("tbl%0d_m1adr", i), m1_adr, tbl[i].adr);
        end

        // Fill to MAX_OUTSTANDING, then one ack frees a slot a cycle later.
        do_reset();
        for (int i = 0; i < MAXO; i++) begin
            @(negedge clk);
            adr = 32'h100 + 32'(4 * i); stb = 1'b1;
            #1;
            chk($sformatf("fill%0d_stall", i), stall, 0);
            chk($sformatf("fill%0d_m0stb", i), m0_stb, 1);
        end
        @(negedge clk); adr = 32'h200; #1;
        chk("full_stall", stall, 1);
        chk("full_m0stb", m0_stb, 0);
        @(negedge clk); m0_ack = 1'b1; #1;
        chk("full_ack_stall", stall, 1);
        chk("full_ack", ack, 1);
        @(negedge clk); m0_ack = 1'b0; #1;
        chk("slot_stall", stall, 0);
        chk("slot_m0stb", m0_stb, 1);
        @(negedge clk); adr = 32'h204; #1;
        chk("refull_stall", stall, 1);

        // Drop cyc with outstanding requests; late ack must not leak.
        @(negedge clk); cyc = 1'b0; stb = 1'b0; #1;
        chk("abort_m0cyc", m0_cyc, 0);
        @(negedge clk); cyc = 1'b1; adr = 32'h1000_0000; m0_ack = 1'b1; #1;
        chk("abort_late_ack", ack, 0);
        chk("abort_m0cyc2", m0_cyc, 0);
        chk("abort_stall", stall, 0);

        // Reset with two outstanding to slave 1.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); adr = 32'h1000_0000; stb = 1'b1; #1;
            chk($sformatf("s1req%0d_m1stb", i), m1_stb, 1);
        end
        @(negedge clk); rst = 1'b1; m1_stall = 1'b1; m1_ack = 1'b1; m1_rdat = 32'hABCD; #1;
        chk("midrst_ack", ack, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_m1stb", m1_stb, 0);
        chk("midrst_m1cyc", m1_cyc, 0);
        chk("midrst_dat", rdat, 0);
        @(negedge clk); rst = 1'b0; m1_stall = 1'b0; stb = 1'b0; adr = 32'h0; #1;
        chk("postrst_late_ack", ack, 0);
        chk("postrst_m1cyc", m1_cyc, 0);
        chk("postrst_dat", rdat, 0);

        // Pending unmapped ack is cancelled by a cyc drop.
        @(negedge clk); m1_ack = 1'b0; adr = 32'h2000_0000; stb = 1'b1; #1;
        chk("unm_stall", stall, 0);
        @(negedge clk); cyc = 1'b0; stb = 1'b0; #1;
        chk("unm_cancel_ack", ack, 0);
        @(negedge clk); cyc = 1'b1; #1;
        chk("unm_cancel_ack2", ack, 0);

        // Randomised traffic against the queue model.
        do_reset();
        oq.delete(); last_t = 2; unm_cyc = -10; cno = 0;
        for (int c = 0; c < 3000; c++) begin
            int      n, d, front;
            bit      own, sst, e_stall, e_ack, acc, s_cyc;
            logic [31:0] e_dat;
            logic [3:0]  rg;
            @(negedge clk);
            case ($urandom_range(0, 3))
                0: rg = 4'h0;
                1: rg = 4'h1;
                2: rg = 4'h2;
                default: rg = 4'hF;
            endcase
            adr = {rg, 28'($urandom)};
            wdat = $urandom; we = 1'($urandom); sel = 4'($urandom);
            stb = $urandom_range(0, 99) < 60;
            cyc = $urandom_range(0, 99) < 95;
            m0_ack = $urandom_range(0, 99) < 35;
            m1_ack = $urandom_range(0, 99) < 35;
            m0_stall = $urandom_range(0, 99) < 20;
            m1_stall = $urandom_range(0, 99) < 20;
            m0_rdat = $urandom; m1_rdat = $urandom;
            #1;
            s_cyc = cyc;
            n = oq.size();
            d = region(adr);
            front = (n != 0) ? oq[0] : -1;
            own = (n == MAXO) || (n != 0 && d != front);
            sst = (d == 0) ? m0_stall : (d == 1) ? m1_stall : 1'b0;
            e_stall = own || sst;
            e_ack = s_cyc && n != 0 &&
                    ((front == 0) ? m0_ack : (front == 1) ? m1_ack : (unm_cyc == cno - 1));
            e_dat = (last_t == 0) ? m0_rdat : (last_t == 1) ? m1_rdat : 32'h0;
            chk($sformatf("rnd%0d_stall", c), stall, e_stall);
            chk($sformatf("rnd%0d_ack", c), ack, e_ack);
            chk($sformatf("rnd%0d_dat", c), rdat, e_dat);
            chk($sformatf("rnd%0d_m0stb", c), m0_stb, stb && s_cyc && d == 0 && !own);
            chk($sformatf("rnd%0d_m1stb", c), m1_stb, stb && s_cyc && d == 1 && !own);
            chk($sformatf("rnd%0d_m0cyc", c), m0_cyc, s_cyc && ((n != 0 && front == 0) || d == 0));
            chk($sformatf("rnd%0d_m1cyc", c), m1_cyc, s_cyc && ((n != 0 && front == 1) || d == 1));
            acc = s_cyc && stb && !e_stall;
            if (!s_cyc) begin
                oq.delete();
                last_t = 2;
                unm_cyc = -10;
            end else begin
                if (e_ack) void'(oq.pop_front());
                if (acc) begin
                    oq.push_back(d);
                    last_t = d;
                    if (d == 2) unm_cyc = cno;
                end
            end
            cno++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
